// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  localparam int TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping to 0.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_any
);

  // Scan from farthest to nearest so the nearest set bit overwrites the others.
  always_comb begin
    o_winner = '0;
    o_any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
        o_winner = ID_W'((int'(i_ptr) + k) % NUM_REQ);
        o_any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single uart_tx from NUM_REQ byte sources.
// Optional tx_ready start timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ID_W           = 3,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_byte,
  output logic                 tx_en,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  state_e             r_state;
  logic [7:0]         r_tx_byte;
  logic               r_tx_en;
  logic [NUM_REQ-1:0] r_req_ready;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_busy;
  logic [ID_W-1:0]    r_rr_ptr;

  logic [ID_W-1:0]    w_winner;
  logic               w_any;
  logic [ID_W-1:0]    w_next_ptr;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   r_cnt;
  logic               r_timeout_err;
  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req    (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // Explicit wrap keeps the pointer inside 0..NUM_REQ-1 for any NUM_REQ.
  assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_tx_byte     <= '0;
      r_tx_en       <= 1'b0;
      r_req_ready   <= '0;
      r_grant_id    <= '0;
      r_busy        <= 1'b0;
      r_rr_ptr      <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_req_ready <= '0;
      case (r_state)
        IDLE: begin
          if (w_any && tx_ready) begin
            r_tx_byte   <= req_byte[8*int'(w_winner) +: 8];
            r_grant_id  <= w_winner;
            r_req_ready <= NUM_REQ'(1) << w_winner;
            r_busy      <= 1'b1;
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          r_tx_en <= 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_ready) begin
            r_tx_en <= 1'b0;
            r_state <= WAIT_DONE;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
            r_tx_en       <= 1'b0;
            r_rr_ptr      <= w_next_ptr;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            r_rr_ptr <= w_next_ptr;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign tx_byte   = r_tx_byte;
  assign tx_en     = r_tx_en;
  assign grant_id  = r_grant_id;
  assign busy      = r_busy;

endmodule
